// File: rtl/pipe_pkg.sv
// Shared opcode, result-class and divider-state encodings for the pipeline EX stage.
package pipe_pkg;

  localparam logic [6:0] ALUOP_AND  = 7'h01;
  localparam logic [6:0] ALUOP_OR   = 7'h02;
  localparam logic [6:0] ALUOP_XOR  = 7'h03;
  localparam logic [6:0] ALUOP_SLL  = 7'h04;
  localparam logic [6:0] ALUOP_SRL  = 7'h05;
  localparam logic [6:0] ALUOP_SRA  = 7'h06;
  localparam logic [6:0] ALUOP_ADD  = 7'h07;
  localparam logic [6:0] ALUOP_SUB  = 7'h08;
  localparam logic [6:0] ALUOP_SLT  = 7'h09;
  localparam logic [6:0] ALUOP_SLTU = 7'h0A;
  localparam logic [6:0] ALUOP_DIV  = 7'h0B;
  localparam logic [6:0] ALUOP_DIVU = 7'h0C;
  localparam logic [6:0] ALUOP_REM  = 7'h0D;
  localparam logic [6:0] ALUOP_REMU = 7'h0E;

  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;
  localparam logic [2:0] SEL_DIV   = 3'd4;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider: magnitudes are divided over XLEN cycles and
// the sign fix is applied on the way out in DONE.
module div_iter
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic            rem_op,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v, input logic en);
    return (en && v < 0) ? -v : v;
  endfunction

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, remop_q, remop_d;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN:0]    shifted, diff;

  assign a_s     = a;
  assign b_s     = b;
  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    remop_d = remop_q;
    busy    = 1'b0;
    done    = 1'b0;
    if (flush) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: if (start) begin
          busy    = 1'b1;
          cnt_d   = '0;
          remop_d = rem_op;
          qneg_d  = 1'b0;
          rneg_d  = 1'b0;
          if (b == '0) begin
            quot_d  = '1;
            rem_d   = a;
            state_d = DIV_DONE;
          end else if (signed_op && a == MIN_NEG && b == '1) begin
            quot_d  = MIN_NEG;
            rem_d   = '0;
            state_d = DIV_DONE;
          end else begin
            quot_d  = mag(a_s, signed_op);
            rem_d   = '0;
            dvsr_d  = mag(b_s, signed_op);
            qneg_d  = signed_op && ((a_s < 0) != (b_s < 0));
            rneg_d  = signed_op && (a_s < 0);
            state_d = DIV_CALC;
          end
        end
        DIV_CALC: begin
          busy = 1'b1;
          // Restoring step: keep the trial difference only when it did not borrow.
          if (!diff[XLEN]) begin
            rem_d  = diff[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d  = shifted[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = DIV_DONE;
        end
        DIV_DONE: begin
          done    = 1'b1;
          state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  assign result = remop_q ? (rneg_q ? -rem_q : rem_q)
                          : (qneg_q ? -quot_q : quot_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    quot_q  <= quot_d;
    rem_q   <= rem_d;
    dvsr_q  <= dvsr_d;
    qneg_q  <= qneg_d;
    rneg_q  <= rneg_d;
    remop_q <= remop_d;
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU mux plus iterative divider, registering
// {wd, wreg, wdata} toward MEM and stalling upstream while a divide runs.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            ex_aluop,
  input  logic [2:0]            ex_alusel,
  input  logic [XLEN-1:0]       ex_reg1,
  input  logic [XLEN-1:0]       ex_reg2,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic                  flush,
  output logic                  stall_req,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [XLEN-1:0]       mem_wdata
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic signed [XLEN-1:0] op1_s, op2_s;
  logic [SHAMT_W-1:0]     shamt;
  logic                   div_op, div_signed, div_rem, div_busy, div_done;
  logic [XLEN-1:0]        div_result, alu_res;
  logic [REG_ADDR_W-1:0]  wd_q, wd_d;
  logic                   wreg_q, wreg_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;

  assign op1_s      = ex_reg1;
  assign op2_s      = ex_reg2;
  assign shamt      = ex_reg2[SHAMT_W-1:0];
  assign div_op     = (ex_alusel == SEL_DIV) &&
                      (ex_aluop == ALUOP_DIV || ex_aluop == ALUOP_DIVU ||
                       ex_aluop == ALUOP_REM || ex_aluop == ALUOP_REMU);
  assign div_signed = (ex_aluop == ALUOP_DIV) || (ex_aluop == ALUOP_REM);
  assign div_rem    = (ex_aluop == ALUOP_REM) || (ex_aluop == ALUOP_REMU);

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_op),
    .signed_op (div_signed),
    .rem_op    (div_rem),
    .flush     (flush),
    .a         (ex_reg1),
    .b         (ex_reg2),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  assign stall_req = div_busy;

  always_comb begin
    alu_res = '0;
    case (ex_alusel)
      SEL_LOGIC: case (ex_aluop)
        ALUOP_AND: alu_res = ex_reg1 & ex_reg2;
        ALUOP_OR:  alu_res = ex_reg1 | ex_reg2;
        ALUOP_XOR: alu_res = ex_reg1 ^ ex_reg2;
        default:   alu_res = '0;
      endcase
      SEL_SHIFT: case (ex_aluop)
        ALUOP_SLL: alu_res = ex_reg1 << shamt;
        ALUOP_SRL: alu_res = ex_reg1 >> shamt;
        ALUOP_SRA: alu_res = op1_s >>> shamt;
        default:   alu_res = '0;
      endcase
      SEL_ARITH: case (ex_aluop)
        ALUOP_ADD:  alu_res = ex_reg1 + ex_reg2;
        ALUOP_SUB:  alu_res = ex_reg1 - ex_reg2;
        ALUOP_SLT:  alu_res = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
        ALUOP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (ex_reg1 < ex_reg2)};
        default:    alu_res = '0;
      endcase
      SEL_DIV: if (div_op && div_done) alu_res = div_result;
      default: alu_res = '0;
    endcase
  end

  // Stall or flush turns the MEM-bound slot into a bubble.
  always_comb begin
    wd_d    = ex_wd;
    wreg_d  = ex_wreg;
    wdata_d = alu_res;
    if (flush || stall_req) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed ALU, divide, special-case, flush and back-to-back vectors.
module tb_ex_stage;
  import pipe_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [6:0]      ex_aluop;
  logic [2:0]      ex_alusel;
  logic [XLEN-1:0] ex_reg1, ex_reg2;
  logic [RW-1:0]   ex_wd;
  logic            ex_wreg, flush;
  logic            stall_req;
  logic [RW-1:0]   mem_wd;
  logic            mem_wreg;
  logic [XLEN-1:0] mem_wdata;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_aluop  (ex_aluop),
    .ex_alusel (ex_alusel),
    .ex_reg1   (ex_reg1),
    .ex_reg2   (ex_reg2),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .flush     (flush),
    .stall_req (stall_req),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata)
  );

  typedef struct packed {
    logic [RW-1:0]   wd;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always @(negedge clk) begin
    if (!rst && mem_wreg) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual wd=%0d data=%h, required no write", mem_wd, mem_wdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (mem_wd !== e.wd || mem_wdata !== e.data) begin
          failures++;
          $display("FAIL mem_result actual wd=%0d data=%h, required wd=%0d data=%h",
                   mem_wd, mem_wdata, e.wd, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wreg);
    ex_aluop  = op;
    ex_alusel = sel;
    ex_reg1   = a;
    ex_reg2   = b;
    ex_wd     = wd;
    ex_wreg   = wreg;
  endtask

  task automatic issue(input string name, input logic [6:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] exp, input int exp_stall);
    int n = 0;
    bit bubble_ok = 1'b1;
    @(negedge clk);
    drive(op, sel, a, b, wd, wreg);
    flush = 1'b0;
    if (wreg) sb_q.push_back({wd, exp});
    #1;
    while (stall_req && n < 100) begin
      n++;
      @(posedge clk);
      #1;
      if (mem_wreg !== 1'b0 || mem_wdata !== '0 || mem_wd !== '0) bubble_ok = 1'b0;
    end
    chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    if (exp_stall > 0) chk({name, "_bubble"}, 32'(bubble_ok), 32'd1);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    drive(ALUOP_ADD, SEL_ARITH, 32'd3, 32'd4, 5'd7, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wd",    32'(mem_wd),    32'd0);
    chk("reset_wreg",  32'(mem_wreg),  32'd0);
    chk("reset_wdata", mem_wdata,      32'd0);
    chk("reset_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(ALUOP_AND, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);

    issue("add_wrap", ALUOP_ADD,  SEL_ARITH, 32'h7FFFFFFF, 32'h1, 5'd5, 1'b1, 32'h80000000, 0);
    issue("sra",      ALUOP_SRA,  SEL_SHIFT, 32'h80000000, 32'h4, 5'd6, 1'b1, 32'hF8000000, 0);
    issue("sltu",     ALUOP_SLTU, SEL_ARITH, 32'h1, 32'hFFFFFFFF, 5'd7, 1'b1, 32'h1, 0);
    issue("slt",      ALUOP_SLT,  SEL_ARITH, 32'hFFFFFFFF, 32'h1, 5'd8, 1'b1, 32'h1, 0);
    issue("sub_wrap", ALUOP_SUB,  SEL_ARITH, 32'h0, 32'h1, 5'd9, 1'b1, 32'hFFFFFFFF, 0);
    issue("and",      ALUOP_AND,  SEL_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 5'd10, 1'b1, 32'hF000F000, 0);
    issue("or",       ALUOP_OR,   SEL_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 5'd11, 1'b1, 32'hFFF0FFF0, 0);
    issue("xor",      ALUOP_XOR,  SEL_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 5'd12, 1'b1, 32'h0FF00FF0, 0);
    issue("sll_mask", ALUOP_SLL,  SEL_SHIFT, 32'h1, 32'h3F, 5'd13, 1'b1, 32'h80000000, 0);
    issue("srl",      ALUOP_SRL,  SEL_SHIFT, 32'h80000000, 32'h4, 5'd14, 1'b1, 32'h08000000, 0);
    issue("bad_pair", ALUOP_ADD,  SEL_LOGIC, 32'h5, 32'h6, 5'd15, 1'b1, 32'h0, 0);
    issue("nop",      ALUOP_ADD,  SEL_NOP,   32'h5, 32'h6, 5'd16, 1'b1, 32'h0, 0);

    issue("div_m7_2",  ALUOP_DIV,  SEL_DIV, 32'hFFFFFFF9, 32'h2, 5'd17, 1'b1, 32'hFFFFFFFD, 33);
    issue("rem_m7_2",  ALUOP_REM,  SEL_DIV, 32'hFFFFFFF9, 32'h2, 5'd18, 1'b1, 32'hFFFFFFFF, 33);
    issue("divu_100_7", ALUOP_DIVU, SEL_DIV, 32'd100, 32'd7, 5'd19, 1'b1, 32'd14, 33);
    issue("remu_100_7", ALUOP_REMU, SEL_DIV, 32'd100, 32'd7, 5'd20, 1'b1, 32'd2, 33);
    issue("rem_7_m2",  ALUOP_REM,  SEL_DIV, 32'd7, 32'hFFFFFFFE, 5'd21, 1'b1, 32'd1, 33);

    issue("divu_by0",  ALUOP_DIVU, SEL_DIV, 32'd1234, 32'd0, 5'd22, 1'b1, 32'hFFFFFFFF, 1);
    issue("rem_by0",   ALUOP_REM,  SEL_DIV, 32'd9, 32'd0, 5'd23, 1'b1, 32'd9, 1);
    issue("div_ovf",   ALUOP_DIV,  SEL_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd24, 1'b1, 32'h80000000, 1);

    // Flush during cycle 10 of a divide, then an ADD must go straight through.
    @(negedge clk);
    drive(ALUOP_DIV, SEL_DIV, 32'hFFFFFFF9, 32'h2, 5'd25, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    chk("flush_pre_stall", 32'(stall_req), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_bubble_wreg",  32'(mem_wreg), 32'd0);
    chk("flush_bubble_wdata", mem_wdata,     32'd0);
    flush = 1'b0;
    drive(ALUOP_ADD, SEL_ARITH, 32'd3, 32'd4, 5'd26, 1'b1);
    sb_q.push_back({5'd26, 32'd7});
    #1;
    chk("post_flush_stall", 32'(stall_req), 32'd0);
    @(posedge clk);

    issue("b2b_div",  ALUOP_DIV,  SEL_DIV, 32'd100, 32'hFFFFFFF9, 5'd27, 1'b1, 32'hFFFFFFF2, 33);
    issue("b2b_divu", ALUOP_DIVU, SEL_DIV, 32'd100, 32'd7, 5'd28, 1'b1, 32'd14, 33);

    @(negedge clk);
    drive(ALUOP_AND, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
